// File: rtl/deca_qsys_status_pio_irq.sv
// Status input port with per-bit edge capture, interrupt mask and a
// registered interrupt request. WIDTH asynchronous status lines are
// synchronised, edge-detected and exposed on a 4-word register map:
//   0 data (read-only), 1 irq_mask, 2 reserved (reads 0), 3 edge_capture.
module deca_qsys_status_pio_irq #(
   parameter int          WIDTH       = 4,
   parameter int          SYNC_STAGES = 2,
   parameter int          EDGE_TYPE   = 0,
   parameter int          IRQ_TYPE    = 1,
   parameter logic [31:0] RESET_MASK  = 32'h0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       address,
   input  logic             write,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   // The arm counter must hold SYNC_STAGES+1, which always fits in ARM_W bits.
   localparam int              ARM_W    = $clog2(SYNC_STAGES + 2);
   localparam logic [ARM_W-1:0] ARM_INIT = ARM_W'(SYNC_STAGES + 1);

   logic [WIDTH-1:0] sync_q [SYNC_STAGES-1];
   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] prev_q;
   logic [WIDTH-1:0] edge_capture_q, edge_capture_d;
   logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
   logic [ARM_W-1:0] arm_q, arm_d;
   logic [31:0]      readdata_q, readdata_d;
   logic             irq_q, irq_d;

   logic [WIDTH-1:0] rise, fall, edge_hit, clr;

   // Upper writedata bits are ignored when WIDTH < 32.
   logic unused_writedata;
   assign unused_writedata = ^writedata;

   // Next-state logic: edge selection, capture/clear, mask, irq and read mux.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      rise           = data_q & ~prev_q;
      fall           = ~data_q & prev_q;
      edge_hit       = '0;
      clr            = '0;
      edge_capture_d = edge_capture_q;
      irq_mask_d     = irq_mask_q;
      arm_d          = arm_q;
      readdata_d     = '0;
      irq_d          = 1'b0;

      case (EDGE_TYPE)
         0:       edge_hit = rise;
         1:       edge_hit = fall;
         default: edge_hit = rise | fall;
      endcase

      // Lines already active at reset would look like edges while the
      // synchroniser fills; ignore everything until the counter expires.
      if (arm_q != '0) begin
         edge_hit = '0;
         arm_d    = arm_q - ARM_W'(1);
      end

      if (write && address == 2'd3) clr = writedata[WIDTH-1:0];
      // Set is applied after clear so a coincident new edge is never lost.
      edge_capture_d = (edge_capture_q & ~clr) | edge_hit;

      if (write && address == 2'd1) irq_mask_d = writedata[WIDTH-1:0];

      if (IRQ_TYPE != 0) irq_d = |(edge_capture_q & irq_mask_q);
      else               irq_d = |(data_q & irq_mask_q);

      // Read mux uses current register values, so a same-cycle write is not seen.
      case (address)
         2'd0:    readdata_d[WIDTH-1:0] = data_q;
         2'd1:    readdata_d[WIDTH-1:0] = irq_mask_q;
         2'd3:    readdata_d[WIDTH-1:0] = edge_capture_q;
         default: readdata_d            = '0;
      endcase
   end

   // State registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: the synchroniser array is ordinary flops, so it is reset like any other register.
         for (int i = 0; i < SYNC_STAGES - 1; i++) sync_q[i] <= '0;
         data_q         <= '0;
         prev_q         <= '0;
         edge_capture_q <= '0;
         irq_mask_q     <= RESET_MASK[WIDTH-1:0];
         arm_q          <= ARM_INIT;
         readdata_q     <= '0;
         irq_q          <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every stage samples the pre-edge value.
         sync_q[0] <= in_port;
         for (int i = 1; i < SYNC_STAGES - 1; i++) sync_q[i] <= sync_q[i-1];
         data_q         <= sync_q[SYNC_STAGES-2];
         prev_q         <= data_q;
         edge_capture_q <= edge_capture_d;
         irq_mask_q     <= irq_mask_d;
         arm_q          <= arm_d;
         readdata_q     <= readdata_d;
         irq_q          <= irq_d;
      end
   end

   assign readdata = readdata_q;
   assign irq      = irq_q;

endmodule

// File: tb/tb_deca_qsys_status_pio_irq.sv
// Self-checking bench for deca_qsys_status_pio_irq. Three instances cover the
// default edge-IRQ configuration, level-IRQ mode and a 32-bit any-edge port.
module tb_deca_qsys_status_pio_irq;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  address;
   logic [31:0] writedata;
   logic        write_m, write_l, write_w;
   logic [3:0]  in_m, in_l;
   logic [31:0] in_w;
   logic [31:0] rd_m, rd_l, rd_w;
   logic        irq_m, irq_l, irq_w;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   deca_qsys_status_pio_irq #(
      .WIDTH(4), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_TYPE(1), .RESET_MASK(32'h0)
   ) u_main (
      .clk(clk), .reset(reset), .address(address), .write(write_m),
      .writedata(writedata), .readdata(rd_m), .in_port(in_m), .irq(irq_m)
   );

   deca_qsys_status_pio_irq #(
      .WIDTH(4), .SYNC_STAGES(3), .EDGE_TYPE(0), .IRQ_TYPE(0), .RESET_MASK(32'h0)
   ) u_lvl (
      .clk(clk), .reset(reset), .address(address), .write(write_l),
      .writedata(writedata), .readdata(rd_l), .in_port(in_l), .irq(irq_l)
   );

   deca_qsys_status_pio_irq #(
      .WIDTH(32), .SYNC_STAGES(2), .EDGE_TYPE(2), .IRQ_TYPE(1), .RESET_MASK(32'h8000_0000)
   ) u_wide (
      .clk(clk), .reset(reset), .address(address), .write(write_w),
      .writedata(writedata), .readdata(rd_w), .in_port(in_w), .irq(irq_w)
   );

   typedef struct {
      logic [3:0]  in_port;
      logic        wr;
      logic [1:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic        exp_irq;
   } vec_t;

   vec_t vecs [32];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One clock: inputs were driven at the falling edge, outputs sampled at the next one.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic bus_write(input int which, input logic [1:0] a, input logic [31:0] d);
      address   = a;
      writedata = d;
      write_m   = (which == 0);
      write_l   = (which == 1);
      write_w   = (which == 2);
      tick();
      write_m = 1'b0;
      write_l = 1'b0;
      write_w = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      // One row per clock on the 4-bit edge-IRQ instance (2 sync stages).
      vecs[0]  = '{4'h0, 1'b1, 2'd1, 32'h1,         32'h0, 1'b0};
      vecs[1]  = '{4'h0, 1'b0, 2'd1, 32'h0,         32'h1, 1'b0};
      vecs[2]  = '{4'h0, 1'b0, 2'd0, 32'h0,         32'h0, 1'b0};
      vecs[3]  = '{4'h1, 1'b0, 2'd3, 32'h0,         32'h0, 1'b0};
      vecs[4]  = '{4'h1, 1'b0, 2'd3, 32'h0,         32'h0, 1'b0};
      vecs[5]  = '{4'h1, 1'b0, 2'd3, 32'h0,         32'h0, 1'b0};
      vecs[6]  = '{4'h1, 1'b0, 2'd3, 32'h0,         32'h1, 1'b1};
      vecs[7]  = '{4'h1, 1'b1, 2'd3, 32'h1,         32'h1, 1'b1};
      vecs[8]  = '{4'h1, 1'b0, 2'd3, 32'h0,         32'h0, 1'b0};
      vecs[9]  = '{4'h3, 1'b1, 2'd1, 32'h3,         32'h1, 1'b0};
      vecs[10] = '{4'h3, 1'b0, 2'd3, 32'h0,         32'h0, 1'b0};
      vecs[11] = '{4'h3, 1'b1, 2'd3, 32'h2,         32'h0, 1'b0};
      vecs[12] = '{4'h1, 1'b0, 2'd3, 32'h0,         32'h2, 1'b1};
      vecs[13] = '{4'h3, 1'b0, 2'd3, 32'h0,         32'h2, 1'b1};
      vecs[14] = '{4'h3, 1'b0, 2'd3, 32'h0,         32'h2, 1'b1};
      vecs[15] = '{4'h3, 1'b1, 2'd3, 32'h2,         32'h2, 1'b1};
      vecs[16] = '{4'h3, 1'b0, 2'd3, 32'h0,         32'h2, 1'b1};
      vecs[17] = '{4'h3, 1'b1, 2'd3, 32'h2,         32'h2, 1'b1};
      vecs[18] = '{4'h3, 1'b0, 2'd3, 32'h0,         32'h0, 1'b0};
      vecs[19] = '{4'h0, 1'b1, 2'd1, 32'h0,         32'h3, 1'b0};
      vecs[20] = '{4'h0, 1'b0, 2'd0, 32'h0,         32'h3, 1'b0};
      vecs[21] = '{4'hF, 1'b0, 2'd0, 32'h0,         32'h0, 1'b0};
      vecs[22] = '{4'hF, 1'b0, 2'd0, 32'h0,         32'h0, 1'b0};
      vecs[23] = '{4'hF, 1'b0, 2'd3, 32'h0,         32'h0, 1'b0};
      vecs[24] = '{4'hF, 1'b0, 2'd3, 32'h0,         32'hF, 1'b0};
      vecs[25] = '{4'hF, 1'b0, 2'd3, 32'h0,         32'hF, 1'b0};
      vecs[26] = '{4'hF, 1'b1, 2'd1, 32'h8,         32'h0, 1'b0};
      vecs[27] = '{4'hF, 1'b0, 2'd1, 32'h0,         32'h8, 1'b1};
      vecs[28] = '{4'hF, 1'b1, 2'd1, 32'hFFFF_FFF8, 32'h8, 1'b1};
      vecs[29] = '{4'hF, 1'b0, 2'd1, 32'h0,         32'h8, 1'b1};
      vecs[30] = '{4'hF, 1'b1, 2'd3, 32'hFFFF_FFFF, 32'hF, 1'b1};
      vecs[31] = '{4'hF, 1'b0, 2'd3, 32'h0,         32'h0, 1'b0};

      // Reset with status lines already high on the main instance.
      reset     = 1'b1;
      address   = 2'd0;
      writedata = 32'h0;
      write_m   = 1'b0;
      write_l   = 1'b0;
      write_w   = 1'b0;
      in_m      = 4'hF;
      in_l      = 4'h0;
      in_w      = 32'h0;
      repeat (3) tick();
      check("reset_rd_main", rd_m, 32'h0);
      check("reset_irq_main", {31'b0, irq_m}, 32'h0);
      check("reset_rd_wide", rd_w, 32'h0);
      check("reset_irq_wide", {31'b0, irq_w}, 32'h0);

      reset   = 1'b0;
      address = 2'd3;
      repeat (10) tick();
      check("t1_edge_capture", rd_m, 32'h0);
      check("t1_irq", {31'b0, irq_m}, 32'h0);
      address = 2'd0;
      tick();
      check("t1_data", rd_m, 32'h0000_000F);
      address = 2'd1;
      tick();
      check("t1_mask_main", rd_m, 32'h0);
      check("t1_mask_wide", rd_w, 32'h8000_0000);

      // Rising capture, clear, set/clear collision, masking.
      for (int i = 0; i < 32; i++) begin
         in_m      = vecs[i].in_port;
         address   = vecs[i].addr;
         writedata = vecs[i].wdata;
         write_m   = vecs[i].wr;
         tick();
         write_m = 1'b0;
         check($sformatf("vec%0d_rd", i), rd_m, vecs[i].exp_rd);
         check($sformatf("vec%0d_irq", i), {31'b0, irq_m}, {31'b0, vecs[i].exp_irq});
      end

      // Reset in mid-operation with a pending capture and a line held high.
      in_m    = 4'h0;
      address = 2'd3;
      repeat (3) tick();
      in_m = 4'h8;
      repeat (4) tick();
      check("midrst_pre_rd", rd_m, 32'h8);
      check("midrst_pre_irq", {31'b0, irq_m}, 32'h1);
      reset = 1'b1;
      tick();
      check("midrst_rd", rd_m, 32'h0);
      check("midrst_irq", {31'b0, irq_m}, 32'h0);
      reset = 1'b0;
      repeat (6) tick();
      check("midrst_post_ec", rd_m, 32'h0);
      check("midrst_post_irq", {31'b0, irq_m}, 32'h0);
      address = 2'd1;
      tick();
      check("midrst_post_mask", rd_m, 32'h0);

      // Level mode, 3 sync stages: irq follows in_port[1] four clocks later.
      bus_write(1, 2'd1, 32'h2);
      in_l = 4'b0010;
      for (int k = 1; k <= 4; k++) begin
         tick();
         check($sformatf("lvl_rise_t%0d", k), {31'b0, irq_l}, {31'b0, (k == 4)});
      end
      in_l = 4'b0000;
      for (int k = 1; k <= 4; k++) begin
         tick();
         check($sformatf("lvl_fall_t%0d", k), {31'b0, irq_l}, {31'b0, (k < 4)});
      end
      in_l = 4'b0001;
      repeat (6) tick();
      check("lvl_unmasked", {31'b0, irq_l}, 32'h0);

      // 32-bit any-edge port, bit 31 masked at reset.
      in_w    = 32'h8000_0000;
      address = 2'd3;
      repeat (3) tick();
      check("wide_rise_ec_early", rd_w, 32'h0);
      tick();
      check("wide_rise_ec", rd_w, 32'h8000_0000);
      check("wide_rise_irq", {31'b0, irq_w}, 32'h1);
      bus_write(2, 2'd3, 32'h8000_0000);
      address = 2'd3;
      tick();
      check("wide_clr_ec", rd_w, 32'h0);
      check("wide_clr_irq", {31'b0, irq_w}, 32'h0);
      in_w = 32'h0;
      repeat (4) tick();
      check("wide_fall_ec", rd_w, 32'h8000_0000);
      check("wide_fall_irq", {31'b0, irq_w}, 32'h1);
      bus_write(2, 2'd0, 32'hFFFF_FFFF);
      bus_write(2, 2'd2, 32'hFFFF_FFFF);
      address = 2'd0;
      tick();
      check("wide_addr0_ro", rd_w, 32'h0);
      address = 2'd2;
      tick();
      check("wide_addr2_zero", rd_w, 32'h0);
      address = 2'd1;
      tick();
      check("wide_mask_kept", rd_w, 32'h8000_0000);
      address = 2'd3;
      tick();
      check("wide_ec_kept", rd_w, 32'h8000_0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
